// File: rtl/rv32i_exec_ctrl_pkg.sv
// Shared encodings for the RV32I execute/control slice: opcodes, immediate
// formats, ALU operations, branch kinds and ALU operand selects.
package rv32i_exec_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_U = 3'b001;
    localparam logic [2:0] EXT_S = 3'b010;
    localparam logic [2:0] EXT_B = 3'b011;
    localparam logic [2:0] EXT_J = 3'b100;

    // Bit 3 selects the alternate form (sub/sra) and unsigned compare.
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b1010;
    localparam logic [3:0] ALU_COPYB = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam logic [2:0] BR_EQ   = 3'b100;
    localparam logic [2:0] BR_NE   = 3'b101;
    localparam logic [2:0] BR_LT   = 3'b110;
    localparam logic [2:0] BR_GE   = 3'b111;

    localparam logic       ASRC_RS1  = 1'b0;
    localparam logic       ASRC_PC   = 1'b1;
    localparam logic [1:0] BSRC_RS2  = 2'b00;
    localparam logic [1:0] BSRC_IMM  = 2'b01;
    localparam logic [1:0] BSRC_FOUR = 2'b10;

    typedef struct packed {
        logic [2:0] ext_op;
        logic       reg_wr;
        logic       mem_to_reg;
        logic       mem_wr;
        logic [2:0] mem_op;
        logic       alu_asrc;
        logic [1:0] alu_bsrc;
        logic [3:0] alu_ctr;
        logic [2:0] branch;
    } ctrl_t;

endpackage

// File: rtl/rv32_alu.sv
// RV32I ALU: result plus less/zero flags from A vs B, purely combinational.
// Flags are always derived from A and B regardless of which operation is selected.
module rv32_alu
    import rv32i_exec_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_ctr,
    output logic [31:0] result,
    output logic        less,
    output logic        zero
);

    always_comb begin
        less   = alu_ctr[3] ? (a < b) : ($signed(a) < $signed(b));
        zero   = (a == b);
        result = '0;
        case (alu_ctr)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLL:   result = a << b[4:0];
            ALU_SLT,
            ALU_SLTU:  result = {31'b0, less};
            ALU_COPYB: result = b;
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> b[4:0];
            ALU_SRA:   result = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_exec_ctrl.sv
// RV32I execute/control slice: decode, operand mux, ALU and branch condition.
// All outputs except ext_op are registered once (latency 1); ext_op is combinational.
module rv32i_exec_ctrl
    import rv32i_exec_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] imm,
    output logic [2:0]  ext_op,
    output logic        reg_wr,
    output logic        mem_to_reg,
    output logic        mem_wr,
    output logic [2:0]  mem_op,
    output logic [31:0] result,
    output logic        less,
    output logic        zero,
    output logic        pca_src,
    output logic        pcb_src
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    ctrl_t       ctrl;
    logic [31:0] alu_a, alu_b, alu_res;
    logic        alu_less, alu_zero;
    logic        pca_src_d, pcb_src_d;
    logic        unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        ctrl = '0;
        case (opcode)
            OPC_LUI: begin
                ctrl.ext_op = EXT_U;  ctrl.reg_wr = 1'b1;
                ctrl.alu_bsrc = BSRC_IMM;  ctrl.alu_ctr = ALU_COPYB;
            end
            OPC_AUIPC: begin
                ctrl.ext_op = EXT_U;  ctrl.reg_wr = 1'b1;  ctrl.alu_asrc = ASRC_PC;
                ctrl.alu_bsrc = BSRC_IMM;  ctrl.alu_ctr = ALU_ADD;
            end
            OPC_JAL: begin
                ctrl.ext_op = EXT_J;  ctrl.reg_wr = 1'b1;  ctrl.alu_asrc = ASRC_PC;
                ctrl.alu_bsrc = BSRC_FOUR;  ctrl.alu_ctr = ALU_ADD;  ctrl.branch = BR_JAL;
            end
            OPC_JALR: begin
                ctrl.ext_op = EXT_I;  ctrl.reg_wr = 1'b1;  ctrl.alu_asrc = ASRC_PC;
                ctrl.alu_bsrc = BSRC_FOUR;  ctrl.alu_ctr = ALU_ADD;  ctrl.branch = BR_JALR;
            end
            OPC_BRANCH: begin
                ctrl.ext_op   = EXT_B;
                ctrl.alu_bsrc = BSRC_RS2;
                ctrl.alu_ctr  = (funct3[2:1] == 2'b11) ? ALU_SLTU : ALU_SLT;
                case (funct3)
                    3'b000:         ctrl.branch = BR_EQ;
                    3'b001:         ctrl.branch = BR_NE;
                    3'b100, 3'b110: ctrl.branch = BR_LT;
                    3'b101, 3'b111: ctrl.branch = BR_GE;
                    default:        ctrl.branch = BR_NONE;
                endcase
            end
            OPC_LOAD: begin
                ctrl.ext_op = EXT_I;  ctrl.reg_wr = 1'b1;  ctrl.mem_to_reg = 1'b1;
                ctrl.alu_bsrc = BSRC_IMM;  ctrl.alu_ctr = ALU_ADD;  ctrl.mem_op = funct3;
            end
            OPC_STORE: begin
                ctrl.ext_op = EXT_S;  ctrl.mem_wr = 1'b1;
                ctrl.alu_bsrc = BSRC_IMM;  ctrl.alu_ctr = ALU_ADD;  ctrl.mem_op = funct3;
            end
            OPC_OPIMM: begin
                // Only shift-right reads instr[30]; it is an imm bit for addi.
                ctrl.ext_op = EXT_I;  ctrl.reg_wr = 1'b1;  ctrl.alu_bsrc = BSRC_IMM;
                ctrl.alu_ctr = {(funct3 == 3'b101) & instr[30], funct3};
                if (funct3 == 3'b011) ctrl.alu_ctr = ALU_SLTU;
            end
            OPC_OP: begin
                ctrl.reg_wr = 1'b1;  ctrl.alu_bsrc = BSRC_RS2;
                ctrl.alu_ctr = {((funct3 == 3'b000) || (funct3 == 3'b101)) & instr[30], funct3};
                if (funct3 == 3'b011) ctrl.alu_ctr = ALU_SLTU;
            end
            default: ctrl = '0;
        endcase
    end

    always_comb begin
        alu_a = (ctrl.alu_asrc == ASRC_PC) ? pc : rs1;
        case (ctrl.alu_bsrc)
            BSRC_IMM:  alu_b = imm;
            BSRC_FOUR: alu_b = 32'd4;
            default:   alu_b = rs2;
        endcase
    end

    rv32_alu u_alu (
        .a       (alu_a),
        .b       (alu_b),
        .alu_ctr (ctrl.alu_ctr),
        .result  (alu_res),
        .less    (alu_less),
        .zero    (alu_zero)
    );

    always_comb begin
        pca_src_d = 1'b0;
        pcb_src_d = 1'b0;
        case (ctrl.branch)
            BR_JAL:  pca_src_d = 1'b1;
            BR_JALR: begin pca_src_d = 1'b1; pcb_src_d = 1'b1; end
            BR_EQ:   pca_src_d = alu_zero;
            BR_NE:   pca_src_d = ~alu_zero;
            BR_LT:   pca_src_d = alu_less;
            BR_GE:   pca_src_d = ~alu_less;
            default: ;
        endcase
    end

    logic        reg_wr_q, mem_to_reg_q, mem_wr_q, less_q, zero_q, pca_src_q, pcb_src_q;
    logic [2:0]  mem_op_q;
    logic [31:0] result_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reg_wr_q     <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_op_q     <= 3'b000;
            result_q     <= '0;
            less_q       <= 1'b0;
            zero_q       <= 1'b0;
            pca_src_q    <= 1'b0;
            pcb_src_q    <= 1'b0;
        end else begin
            reg_wr_q     <= ctrl.reg_wr;
            mem_to_reg_q <= ctrl.mem_to_reg;
            mem_wr_q     <= ctrl.mem_wr;
            mem_op_q     <= ctrl.mem_op;
            result_q     <= alu_res;
            less_q       <= alu_less;
            zero_q       <= alu_zero;
            pca_src_q    <= pca_src_d;
            pcb_src_q    <= pcb_src_d;
        end
    end

    assign ext_op     = ctrl.ext_op;
    assign reg_wr     = reg_wr_q;
    assign mem_to_reg = mem_to_reg_q;
    assign mem_wr     = mem_wr_q;
    assign mem_op     = mem_op_q;
    assign result     = result_q;
    assign less       = less_q;
    assign zero       = zero_q;
    assign pca_src    = pca_src_q;
    assign pcb_src    = pcb_src_q;

endmodule

// File: tb/tb_rv32i_exec_ctrl.sv
// Scoreboard bench: the driver pushes reference-model expectations, a monitor
// pops one per rising edge and compares against the registered outputs.
module tb_rv32i_exec_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr = '0, pc = '0, rs1 = '0, rs2 = '0, imm = '0;
    logic [2:0]  ext_op;
    logic        reg_wr, mem_to_reg, mem_wr, less, zero, pca_src, pcb_src;
    logic [2:0]  mem_op;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0]  ext_op;
        logic        reg_wr;
        logic        mem_to_reg;
        logic        mem_wr;
        logic [2:0]  mem_op;
        logic [31:0] result;
        logic        less;
        logic        zero;
        logic        pca;
        logic        pcb;
    } exp_t;

    exp_t exp_q[$];

    rv32i_exec_ctrl dut (
        .clock(clock), .reset(reset), .instr(instr), .pc(pc), .rs1(rs1), .rs2(rs2),
        .imm(imm), .ext_op(ext_op), .reg_wr(reg_wr), .mem_to_reg(mem_to_reg),
        .mem_wr(mem_wr), .mem_op(mem_op), .result(result), .less(less), .zero(zero),
        .pca_src(pca_src), .pcb_src(pcb_src)
    );

    always #5 clock = ~clock;

    // Reference model written from instruction semantics.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [31:0] im);
        exp_t e;
        logic [31:0] a, b;
        logic uns, is_op, taken;
        logic [2:0] f3;
        e = '0; a = r1; b = r2; uns = 1'b0; taken = 1'b0;
        f3 = ins[14:12];
        e.result = r1 + r2;
        case (ins[6:0])
            7'b0110111: begin e.ext_op = 3'd1; e.reg_wr = 1; b = im; e.result = im; end
            7'b0010111: begin e.ext_op = 3'd1; e.reg_wr = 1; a = p; b = im; e.result = p + im; end
            7'b1101111: begin e.ext_op = 3'd4; e.reg_wr = 1; a = p; b = 4; e.result = p + 4; e.pca = 1; end
            7'b1100111: begin e.ext_op = 3'd0; e.reg_wr = 1; a = p; b = 4; e.result = p + 4;
                              e.pca = 1; e.pcb = 1; end
            7'b1100011: begin
                e.ext_op = 3'd3;
                uns = (f3 == 3'b110) || (f3 == 3'b111);
                e.result = uns ? {31'b0, r1 < r2} : {31'b0, $signed(r1) < $signed(r2)};
                case (f3)
                    3'b000: taken = (r1 == r2);
                    3'b001: taken = (r1 != r2);
                    3'b100: taken = $signed(r1) < $signed(r2);
                    3'b101: taken = !($signed(r1) < $signed(r2));
                    3'b110: taken = r1 < r2;
                    3'b111: taken = !(r1 < r2);
                    default: taken = 1'b0;
                endcase
                e.pca = taken;
            end
            7'b0000011: begin e.reg_wr = 1; e.mem_to_reg = 1; b = im; e.result = r1 + im; e.mem_op = f3; end
            7'b0100011: begin e.ext_op = 3'd2; e.mem_wr = 1; b = im; e.result = r1 + im; e.mem_op = f3; end
            7'b0010011, 7'b0110011: begin
                is_op = ins[5];
                e.reg_wr = 1;
                b = is_op ? r2 : im;
                case (f3)
                    3'b000: if (is_op && ins[30]) begin e.result = a - b; uns = 1; end
                            else e.result = a + b;
                    3'b001: e.result = a << b[4:0];
                    3'b010: e.result = {31'b0, $signed(a) < $signed(b)};
                    3'b011: begin e.result = {31'b0, a < b}; uns = 1; end
                    3'b100: e.result = a ^ b;
                    3'b101: if (ins[30]) begin e.result = $unsigned($signed(a) >>> b[4:0]); uns = 1; end
                            else e.result = a >> b[4:0];
                    3'b110: e.result = a | b;
                    default: e.result = a & b;
                endcase
            end
            default: ;
        endcase
        e.less = uns ? (a < b) : ($signed(a) < $signed(b));
        e.zero = (a == b);
        return e;
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic b30);
        logic [31:0] r;
        r = $urandom;
        r[6:0] = opc;
        r[14:12] = f3;
        r[30] = b30;
        return r;
    endfunction

    // Drives one instruction on a falling edge and checks the combinational ext_op.
    task automatic apply(input logic [31:0] i_in, input logic [31:0] p_in, input logic [31:0] a_in,
                         input logic [31:0] b_in, input logic [31:0] im_in, input logic mid_reset);
        exp_t e;
        @(negedge clock);
        instr = i_in; pc = p_in; rs1 = a_in; rs2 = b_in; imm = im_in;
        e = model(i_in, p_in, a_in, b_in, im_in);
        exp_q.push_back(e);
        #1;
        checks++;
        if (ext_op !== e.ext_op) begin
            errors++;
            $display("FAIL ext_op instr=%h got=%b exp=%b", i_in, ext_op, e.ext_op);
        end
        if (mid_reset) begin
            reset = 1'b0;
            #1;
            checks++;
            if ({reg_wr, mem_to_reg, mem_wr, mem_op, result, less, zero, pca_src, pcb_src} !== '0) begin
                errors++;
                $display("FAIL mid_reset_zero got=%h exp=0",
                         {reg_wr, mem_to_reg, mem_wr, mem_op, result, less, zero, pca_src, pcb_src});
            end
            #1 reset = 1'b1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({reg_wr, mem_to_reg, mem_wr, mem_op, result, less, zero, pca_src, pcb_src} !==
                    {e.reg_wr, e.mem_to_reg, e.mem_wr, e.mem_op, e.result, e.less, e.zero, e.pca, e.pcb}) begin
                    errors++;
                    $display("FAIL regout instr=%h got wr=%b m2r=%b mwr=%b mop=%b res=%h lt=%b z=%b pca=%b pcb=%b exp wr=%b m2r=%b mwr=%b mop=%b res=%h lt=%b z=%b pca=%b pcb=%b",
                             instr, reg_wr, mem_to_reg, mem_wr, mem_op, result, less, zero, pca_src, pcb_src,
                             e.reg_wr, e.mem_to_reg, e.mem_wr, e.mem_op, e.result, e.less, e.zero, e.pca, e.pcb);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [6:0] opcs [10];
        logic [2:0] bf3 [6];
        logic [31:0] a, b;
        logic [2:0] f3;
        int k;
        opcs = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1111111};
        bf3  = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

        #12;
        checks++;
        if ({reg_wr, mem_to_reg, mem_wr, mem_op, result, less, zero, pca_src, pcb_src} !== '0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=0",
                     {reg_wr, mem_to_reg, mem_wr, mem_op, result, less, zero, pca_src, pcb_src});
        end
        @(negedge clock);
        reset = 1'b1;

        apply(mk(7'b0110011, 3'b000, 1'b0), 32'h0, 32'd7, 32'hFFFF_FFFF, 32'h0, 1'b0);
        apply(mk(7'b0110011, 3'b010, 1'b0), 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0);
        apply(mk(7'b0110011, 3'b011, 1'b0), 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0);
        apply(mk(7'b0010011, 3'b101, 1'b1), 32'h0, 32'h8000_0000, 32'h0, 32'd4, 1'b0);
        apply(mk(7'b0010011, 3'b101, 1'b0), 32'h0, 32'h8000_0000, 32'h0, 32'd4, 1'b0);
        apply(mk(7'b1100011, 3'b000, 1'b0), 32'h40, 32'd5, 32'd5, 32'h10, 1'b0);
        apply(mk(7'b1100011, 3'b001, 1'b0), 32'h40, 32'd5, 32'd5, 32'h10, 1'b0);
        apply(mk(7'b1100011, 3'b111, 1'b0), 32'h40, 32'd1, 32'hFFFF_FFFF, 32'h10, 1'b0);
        apply(mk(7'b1100111, 3'b000, 1'b0), 32'h100, 32'h2000, 32'h3, 32'h8, 1'b0);
        apply(mk(7'b0100011, 3'b010, 1'b0), 32'h0, 32'h1000, 32'h55, 32'h24, 1'b0);
        apply(mk(7'b1111111, 3'b000, 1'b0), 32'h0, 32'h11, 32'h22, 32'h33, 1'b0);
        apply(mk(7'b0110011, 3'b000, 1'b1), 32'h0, 32'd3, 32'd9, 32'h0, 1'b1);
        apply(mk(7'b1101111, 3'b000, 1'b0), 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h200, 1'b0);

        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            f3 = 3'($urandom_range(0, 7));
            if (opcs[k] == 7'b1100011) f3 = bf3[$urandom_range(0, 5)];
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            apply(mk(opcs[k], f3, 1'($urandom_range(0, 1))), $urandom, a, b, $urandom,
                  ($urandom_range(0, 49) == 0));
        end

        repeat (3) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
